// File: rtl/wb_queue_if.sv
// wb_queue_if: request, drain and bypass signals of the write-back queue.
// The flush signal exists only when WBQ_FLUSH_EN is defined.
interface wb_queue_if #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4,
   parameter int DEPTH   = 4
);
   logic                     req_valid;
   logic                     req_ready;
   logic [REGBITS-1:0]       req_wa;
   logic [WIDTH-1:0]         req_wd;
   logic                     wb_hold;
   logic                     regwrite;
   logic [REGBITS-1:0]       wa;
   logic [WIDTH-1:0]         wd;
   logic [REGBITS-1:0]       ra1;
   logic [REGBITS-1:0]       ra2;
   logic                     byp1_hit;
   logic                     byp2_hit;
   logic [WIDTH-1:0]         byp1_data;
   logic [WIDTH-1:0]         byp2_data;
   logic [$clog2(DEPTH):0]   count;
`ifdef WBQ_FLUSH_EN
   logic                     flush;
`endif
   modport master (
`ifdef WBQ_FLUSH_EN
      output flush,
`endif
      output req_valid, req_wa, req_wd, wb_hold, ra1, ra2,
      input  req_ready, regwrite, wa, wd, byp1_hit, byp2_hit, byp1_data, byp2_data, count
   );
   modport slave (
`ifdef WBQ_FLUSH_EN
      input  flush,
`endif
      input  req_valid, req_wa, req_wd, wb_hold, ra1, ra2,
      output req_ready, regwrite, wa, wd, byp1_hit, byp2_hit, byp1_data, byp2_data, count
   );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: write-back FIFO feeding the register-file write port, with read bypass.
// Optional synchronous flush input enabled by defining WBQ_FLUSH_EN.
module wb_queue #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4,
   parameter int DEPTH   = 4
) (
   input logic       clk,
   input logic       rst_n,
   wb_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0]   data_q [DEPTH];
   logic [REGBITS-1:0] addr_q [DEPTH];
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [AW-1:0]      head_q, head_d, tail_q, tail_d, idx;
   logic [CW-1:0]      count_q, count_d;
   logic               flush, ready, push, pop;
   logic               hit1, hit2;
   logic [WIDTH-1:0]   bd1, bd2;
`ifdef WBQ_FLUSH_EN
   assign flush = bus.flush;
`else
   assign flush = 1'b0;
`endif
   // writes to register 0 complete the handshake but are never stored
   assign ready = count_q < CW'(DEPTH);
   assign push  = bus.req_valid & ready & (bus.req_wa != '0) & ~flush;
   assign pop   = (count_q != '0) & ~bus.wb_hold & ~flush;
   assign head_d  = flush ? '0 : head_q + AW'(pop);
   assign tail_d  = flush ? '0 : tail_q + AW'(push);
   assign count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
   always_comb begin
      vld_d = vld_q;
      if (pop) vld_d[head_q] = 1'b0;
      if (push) vld_d[tail_q] = 1'b1;
      if (flush) vld_d = '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[tail_q] <= bus.req_wd;
         addr_q[tail_q] <= bus.req_wa;
      end
   end
   // walk oldest to youngest so the last match found is the youngest
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      bd1  = '0;
      bd2  = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + AW'(k);
         if (vld_q[idx] && bus.ra1 != '0 && addr_q[idx] == bus.ra1) begin
            hit1 = 1'b1;
            bd1  = data_q[idx];
         end
         if (vld_q[idx] && bus.ra2 != '0 && addr_q[idx] == bus.ra2) begin
            hit2 = 1'b1;
            bd2  = data_q[idx];
         end
      end
   end
   assign bus.req_ready = ready;
   assign bus.regwrite  = pop;
   assign bus.wa        = count_q != '0 ? addr_q[head_q] : '0;
   assign bus.wd        = count_q != '0 ? data_q[head_q] : '0;
   assign bus.byp1_hit  = hit1;
   assign bus.byp2_hit  = hit2;
   assign bus.byp1_data = bd1;
   assign bus.byp2_data = bd2;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: random and directed stimulus checked against a queue-based model.
module tb_wb_queue;
   localparam int WIDTH = 16, REGBITS = 4, DEPTH = 4;
   typedef struct packed {
      logic [3:0]  wa;
      logic [15:0] wd;
   } ent_t;
   logic clk = 1'b0;
   logic rst_n;
   ent_t mq[$];
   int   checks = 0, errors = 0;
   always #5 clk = ~clk;
   wb_queue_if #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) bus ();
   wb_queue #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   // youngest pending write to ra, searched from the tail backwards
   task automatic model_byp(input logic [3:0] ra, output logic h, output logic [15:0] d);
      h = 1'b0;
      d = '0;
      if (ra != 4'd0)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].wa == ra) begin
               h = 1'b1;
               d = mq[i].wd;
               break;
            end
   endtask
   task automatic cyc(input logic v, input logic [3:0] a, input logic [15:0] d, input logic h,
                      input logic [3:0] r1, input logic [3:0] r2, input logic f = 1'b0);
      logic        rw, acc, fl, eh;
      logic [3:0]  ewa;
      logic [15:0] ewd, ed;
      bus.req_valid = v;
      bus.req_wa    = a;
      bus.req_wd    = d;
      bus.wb_hold   = h;
      bus.ra1       = r1;
      bus.ra2       = r2;
`ifdef WBQ_FLUSH_EN
      bus.flush = f;
      fl = f;
`else
      fl = 1'b0;
`endif
      #1;
      rw  = mq.size() != 0 && !h && !fl;
      acc = v && mq.size() < DEPTH;
      ewa = '0;
      ewd = '0;
      if (mq.size() != 0) begin
         ewa = mq[0].wa;
         ewd = mq[0].wd;
      end
      check("req_ready", 32'(bus.req_ready), 32'(mq.size() < DEPTH));
      check("regwrite", 32'(bus.regwrite), 32'(rw));
      check("wa", 32'(bus.wa), 32'(ewa));
      check("wd", 32'(bus.wd), 32'(ewd));
      check("count", 32'(bus.count), 32'(mq.size()));
      model_byp(r1, eh, ed);
      check("byp1_hit", 32'(bus.byp1_hit), 32'(eh));
      check("byp1_data", 32'(bus.byp1_data), 32'(ed));
      model_byp(r2, eh, ed);
      check("byp2_hit", 32'(bus.byp2_hit), 32'(eh));
      check("byp2_data", 32'(bus.byp2_data), 32'(ed));
      if (fl) mq.delete();
      else begin
         if (rw) void'(mq.pop_front());
         if (acc && a != 4'd0) mq.push_back(ent_t'{wa: a, wd: d});
      end
      @(posedge clk);
      #1;
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_regwrite"}, 32'(bus.regwrite), 32'd0);
      check({tag, "_wa"}, 32'(bus.wa), 32'd0);
      check({tag, "_wd"}, 32'(bus.wd), 32'd0);
      check({tag, "_count"}, 32'(bus.count), 32'd0);
      check({tag, "_hit1"}, 32'(bus.byp1_hit), 32'd0);
      check({tag, "_hit2"}, 32'(bus.byp2_hit), 32'd0);
   endtask
   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wa = '0;
      bus.req_wd = '0;
      bus.wb_hold = 1'b0;
      bus.ra1 = 4'd3;
      bus.ra2 = 4'd5;
`ifdef WBQ_FLUSH_EN
      bus.flush = 1'b0;
`endif
      #2;
      check_idle("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // single write
      cyc(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd3, 4'd0);
      check("sw_count1", 32'(bus.count), 32'd1);
      check("sw_wa", 32'(bus.wa), 32'd3);
      check("sw_wd", 32'(bus.wd), 32'hBEEF);
      check("sw_hit", 32'(bus.byp1_hit), 32'd1);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 4'd0);
      check("sw_count0", 32'(bus.count), 32'd0);
      check("sw_hit0", 32'(bus.byp1_hit), 32'd0);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 4'd0);
      // fill under hold, fifth request stalls until the hold lifts
      for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 16'(16'h100 + i), 1'b1, 4'd2, 4'd4);
      check("fill_count", 32'(bus.count), 32'd4);
      check("fill_ready", 32'(bus.req_ready), 32'd0);
      cyc(1'b1, 4'd5, 16'h0105, 1'b1, 4'd1, 4'd3);
      check("fill_stall", 32'(bus.count), 32'd4);
      cyc(1'b1, 4'd5, 16'h0105, 1'b0, 4'd1, 4'd3);
      cyc(1'b1, 4'd5, 16'h0105, 1'b0, 4'd5, 4'd4);
      repeat (5) cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd5, 4'd4);
      // same-register bypass picks the youngest
      cyc(1'b1, 4'd5, 16'h0011, 1'b1, 4'd0, 4'd5);
      cyc(1'b1, 4'd5, 16'h0022, 1'b1, 4'd0, 4'd5);
      check("sr_data2", 32'(bus.byp2_data), 32'h0022);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5);
      check("sr_data1", 32'(bus.byp2_data), 32'h0022);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5);
      check("sr_hit0", 32'(bus.byp2_hit), 32'd0);
      // register 0 is accepted but dropped
      cyc(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0);
      check("r0_count", 32'(bus.count), 32'd0);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
      // reset mid-operation
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'(6 + i), 16'(16'h600 + i), 1'b1, 4'd6, 4'd7);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      mq.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      bus.wb_hold = 1'b0;
      @(posedge clk);
      #1;
      repeat (4) cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd6, 4'd7);
`ifdef WBQ_FLUSH_EN
      cyc(1'b1, 4'd2, 16'h0202, 1'b1, 4'd2, 4'd9);
      cyc(1'b1, 4'd3, 16'h0303, 1'b1, 4'd2, 4'd9);
      cyc(1'b1, 4'd9, 16'h0909, 1'b0, 4'd2, 4'd9, 1'b1);
      check("fl_count", 32'(bus.count), 32'd0);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd2, 4'd9);
`endif
      // random traffic
      for (int n = 0; n < 500; n++) begin
         logic f;
`ifdef WBQ_FLUSH_EN
         f = $urandom_range(0, 29) == 0;
`else
         f = 1'b0;
`endif
         cyc(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)), 16'($urandom),
             1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), f);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
